// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes, access
// size codes (funct3[1:0]), FSM state encoding and fault cause codes.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_MISAL   = 2'b01;
   localparam logic [1:0] FC_SIZE    = 2'b10;
   localparam logic [1:0] FC_TIMEOUT = 2'b11;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
//   req_size   : access size of the request being accepted (funct3[1:0])
//   req_off    : addr[1:0] of the request being accepted
//   store_data : rs2 value to be written
//   be, wdata  : bus byte enables and lane-replicated write data
//   ld_funct3  : funct3 of the load in flight
//   ld_off     : addr[1:0] of the load in flight
//   rdata      : word returned by the bus
//   load_data  : extracted, sign/zero-extended load result
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  req_size,
   input  logic [1:0]  req_off,
   input  logic [31:0] store_data,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0] rdata_sh;

   always_comb begin
      be    = 4'b0000;
      wdata = 32'h0;
      case (req_size)
         SZ_B: begin
            be    = 4'b0001 << req_off;
            wdata = {4{store_data[7:0]}};
         end
         SZ_H: begin
            be    = 4'b0011 << req_off;
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = store_data;
         end
      endcase
   end

   // Bring the addressed byte/halfword down to lane 0 before extending.
   assign rdata_sh = rdata >> {ld_off, 3'b000};

   always_comb begin
      load_data = 32'h0;
      case (ld_funct3)
         F3_B:    load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
         F3_H:    load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
         F3_W:    load_data = rdata_sh;
         F3_BU:   load_data = {24'h0, rdata_sh[7:0]};
         F3_HU:   load_data = {16'h0, rdata_sh[15:0]};
         default: load_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit: validates decoder memory requests, runs one req/ack bus
// transaction per access, stalls the core while it is in flight, and
// reports misalignment, illegal size and bus timeout as a fault pulse.
//   clk, rst                  : clock, synchronous active-high reset
//   mem_read, mem_write       : request from the decoder (store wins if both)
//   funct3, addr, store_data  : access size/sign, effective address, rs2
//   rd_in / rd_out            : load destination, returned with done
//   stall                     : hold the pipeline
//   done, load_data           : completion pulse and load result
//   fault, fault_cause        : fault pulse and its code
//   bus_*                     : data-memory bus (req/ack handshake)
//
// state   | meaning
// IDLE    | waiting for a request; faulting requests are rejected here
// REQ     | bus_req high, waiting for bus_ack or the timeout
// DONE    | one-cycle completion, done and rd_out/load_data valid
module lsu_mem_access
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_data,
   input  logic [4:0]        rd_in,
   output logic              stall,
   output logic              done,
   output logic [31:0]       load_data,
   output logic [4:0]        rd_out,
   output logic              fault,
   output logic [1:0]        fault_cause,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   lsu_state_e state, state_nxt;

   logic              req_any, size_bad, misal, req_ok, req_fault;
   logic              accept, capture, timeout;
   logic [CNT_W-1:0]  wait_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        f3_q;
   logic [4:0]        rd_q;
   logic              we_q;
   logic [3:0]        be_q, be_c;
   logic [31:0]       wdata_q, wdata_c;
   logic [31:0]       load_q, load_c;
   logic              fault_q;
   logic [1:0]        cause_q;

   assign req_any = mem_read | mem_write;

   always_comb begin
      size_bad = 1'b0;
      misal    = 1'b0;
      if (mem_write)
         size_bad = !(funct3 inside {F3_B, F3_H, F3_W});
      else
         size_bad = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      case (funct3[1:0])
         SZ_H:    misal = addr[0];
         SZ_W:    misal = (addr[1:0] != 2'b00);
         default: misal = 1'b0;
      endcase
   end

   assign req_ok    = req_any & ~size_bad & ~misal;
   assign req_fault = req_any & (size_bad | misal);

   lsu_align u_align (
      .req_size   (funct3[1:0]),
      .req_off    (addr[1:0]),
      .store_data (store_data),
      .ld_funct3  (f3_q),
      .ld_off     (addr_q[1:0]),
      .rdata      (bus_rdata),
      .be         (be_c),
      .wdata      (wdata_c),
      .load_data  (load_c)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      bus_req   = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      timeout   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_ok) begin
               stall     = 1'b1;
               accept    = 1'b1;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            stall   = 1'b1;
            bus_req = 1'b1;
            // An ack on the expiry cycle still completes the access.
            if (bus_ack) begin
               capture   = 1'b1;
               state_nxt = ST_DONE;
            end else if (wait_cnt == '0) begin
               timeout   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         f3_q     <= 3'b000;
         rd_q     <= 5'd0;
         we_q     <= 1'b0;
         be_q     <= 4'b0000;
         wdata_q  <= 32'h0;
         load_q   <= 32'h0;
         wait_cnt <= '0;
         fault_q  <= 1'b0;
         cause_q  <= FC_NONE;
      end else begin
         fault_q <= 1'b0;
         cause_q <= FC_NONE;
         if (state == ST_IDLE && req_fault) begin
            fault_q <= 1'b1;
            cause_q <= size_bad ? FC_SIZE : FC_MISAL;
         end
         if (timeout) begin
            fault_q <= 1'b1;
            cause_q <= FC_TIMEOUT;
         end
         if (accept) begin
            addr_q   <= addr;
            f3_q     <= funct3;
            rd_q     <= rd_in;
            we_q     <= mem_write;
            be_q     <= be_c;
            wdata_q  <= wdata_c;
            // Down-counter: terminal count 0 marks the last allowed REQ cycle.
            wait_cnt <= CNT_W'(TIMEOUT_CYC - 1);
         end else if (state == ST_REQ && !bus_ack && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
         end
         if (capture)
            load_q <= we_q ? 32'h0 : load_c;
      end
   end

   assign bus_we      = we_q;
   assign bus_addr    = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus_be      = be_q;
   assign bus_wdata   = wdata_q;
   assign rd_out      = rd_q;
   assign load_data   = done ? load_q : 32'h0;
   assign fault       = fault_q;
   assign fault_cause = cause_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
module tb_lsu_mem_access;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0, store_data = 32'h0;
   logic [4:0]  rd_in = 5'd0;
   logic        stall, done, fault, bus_req, bus_we;
   logic [31:0] load_data, bus_addr, bus_wdata;
   logic [4:0]  rd_out;
   logic [1:0]  fault_cause;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   always #5 clk = ~clk;

   lsu_mem_access #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .store_data(store_data), .rd_in(rd_in),
      .stall(stall), .done(done), .load_data(load_data), .rd_out(rd_out),
      .fault(fault), .fault_cause(fault_cause), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   typedef struct {
      bit          is_done;
      logic [1:0]  cause;
      bit          is_load;
      logic [31:0] ld;
      logic [4:0]  rd;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      bit          we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          k;
      int          cyc;
   } bus_t;

   exp_t exp_q[$];
   bus_t bus_q[$];
   int   checks = 0;
   int   failures = 0;
   int   n_pop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, expv, $time);
      end
   endtask

   // Output monitor: every done/fault pulse is matched against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && (done || fault)) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", {30'h0, done, fault}, 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("done", done, e.is_done);
               chk("fault", fault, !e.is_done);
               if (!e.is_done) chk("fault_cause", fault_cause, e.cause);
               if (e.is_done) begin
                  chk("rd_out", rd_out, e.rd);
                  chk("stall_in_done", stall, 0);
                  if (e.is_load) chk("load_data", load_data, e.ld);
               end
            end
            n_pop++;
         end
      end
   end

   // Bus responder: checks the request, acks after k REQ cycles, counts
   // bus_req cycles, and throws spurious acks while the bus is idle.
   initial begin
      bus_t cur;
      bit   active = 0;
      int   cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            active  = 0;
            cnt     = 0;
            bus_ack = 1'b0;
         end else if (bus_req) begin
            if (!active) begin
               if (bus_q.size() == 0) begin
                  chk("unexpected_bus_req", bus_req, 0);
                  cur = '{addr: 0, be: 0, we: 0, wdata: 0, rdata: 0, k: 1000, cyc: TO};
               end else begin
                  cur = bus_q.pop_front();
                  chk("bus_addr", bus_addr, cur.addr);
                  chk("bus_be", bus_be, cur.be);
                  chk("bus_we", bus_we, cur.we);
                  if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
               end
               active = 1;
               cnt    = 0;
            end else begin
               chk("bus_hold", (bus_addr == cur.addr && bus_be == cur.be && bus_we == cur.we) ? 1 : 0, 1);
            end
            chk("stall_in_req", stall, 1);
            if (cnt == cur.k) begin
               bus_ack   = 1'b1;
               bus_rdata = cur.rdata;
            end else begin
               bus_ack   = 1'b0;
               bus_rdata = $urandom;
            end
            cnt++;
         end else begin
            if (active) begin
               chk("bus_req_cycles", cnt, cur.cyc);
               active = 0;
            end
            bus_ack   = ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
         end
      end
   end

   // Reference model + driver for one access. Entered and left at posedge+1.
   task automatic do_txn(input bit rd_i, input bit wr_i, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdat, input logic [4:0] rdn, input int k);
      exp_t e;
      bus_t b;
      bit ill, mis, ok;
      int nb, off, start, cyc;
      logic [31:0] sh, ld, wd;
      logic [1:0] szc;
      szc = f3[1:0];
      if (wr_i) ill = (f3 > 3'd2);
      else      ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      nb  = (szc == 2'd0) ? 1 : (szc == 2'd1) ? 2 : 4;
      off = int'(a % 4);
      mis = (off % nb) != 0;
      ok  = !ill && !mis;
      sh  = rdat >> (8 * off);
      case (f3)
         3'd0: begin ld = sh & 32'hFF;   if (ld >= 32'h80)   ld = ld - 32'h100; end
         3'd1: begin ld = sh & 32'hFFFF; if (ld >= 32'h8000) ld = ld - 32'h10000; end
         3'd2: ld = rdat;
         3'd4: ld = sh & 32'hFF;
         3'd5: ld = sh & 32'hFFFF;
         default: ld = 32'h0;
      endcase
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = 8'(sd >> (8 * (i % nb)));
      e.is_done = ok && (k < TO);
      e.cause   = ill ? 2'b10 : mis ? 2'b01 : 2'b11;
      e.is_load = !wr_i;
      e.ld      = ld;
      e.rd      = rdn;
      exp_q.push_back(e);
      if (ok) begin
         b.addr  = a - 32'(off);
         b.be    = 4'(((1 << nb) - 1) << off);
         b.we    = wr_i;
         b.wdata = wd;
         b.rdata = rdat;
         b.k     = k;
         b.cyc   = (k < TO) ? k + 1 : TO;
         bus_q.push_back(b);
      end
      mem_read = rd_i; mem_write = wr_i; funct3 = f3; addr = a;
      store_data = sd; rd_in = rdn;
      #1 chk("stall_accept", stall, ok);
      start = n_pop;
      @(posedge clk);
      #1;
      mem_read = 1'b0; mem_write = 1'b0;
      funct3 = 3'($urandom); addr = $urandom; store_data = $urandom; rd_in = 5'($urandom);
      cyc = 0;
      while (n_pop == start && cyc < 60) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      if (n_pop == start) chk("txn_complete", n_pop - start, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_txn();
      bit wr, rdq;
      logic [2:0] f3;
      logic [31:0] a;
      int r, nb, k;
      logic [2:0] ld_ok [5];
      ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      wr  = 1'($urandom_range(0, 1));
      rdq = !wr || ($urandom_range(0, 9) == 0);
      r   = $urandom_range(0, 19);
      if (r >= 17)  f3 = 3'($urandom);
      else if (wr)  f3 = 3'($urandom_range(0, 2));
      else          f3 = ld_ok[$urandom_range(0, 4)];
      a  = $urandom;
      nb = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      if ($urandom_range(0, 7) != 0) a = a - (a % nb);
      r = $urandom_range(0, 19);
      if (r < 16)       k = $urandom_range(0, 4);
      else if (r < 18)  k = TO - 1;
      else if (r == 18) k = TO;
      else              k = $urandom_range(6, 14);
      do_txn(rdq, wr, f3, a, $urandom, $urandom, 5'($urandom), k);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_stall", stall, 0);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_be", bus_be, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_load_data", load_data, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      do_txn(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 5'd1, 1);
      do_txn(1, 0, 3'd0, 32'h203, 32'h0, 32'h80FF1234, 5'd2, 0);
      do_txn(1, 0, 3'd4, 32'h203, 32'h0, 32'h80FF1234, 5'd3, 2);
      do_txn(1, 0, 3'd1, 32'h202, 32'h0, 32'h80010000, 5'd4, 0);
      do_txn(1, 0, 3'd5, 32'h202, 32'h0, 32'h80010000, 5'd5, 3);
      do_txn(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 5'd6, 0);
      do_txn(1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 5'd7, 0);
      do_txn(1, 0, 3'd2, 32'h0, 32'h0, 32'h12345678, 5'd8, TO);
      do_txn(1, 0, 3'd2, 32'h0, 32'h0, 32'h12345678, 5'd9, TO - 1);
      do_txn(1, 1, 3'd0, 32'h41, 32'h5A, 32'h0, 5'd10, 0);
      do_txn(0, 1, 3'd4, 32'h40, 32'h5A, 32'h0, 5'd11, 0);

      // Reset during REQ of an SB: no done/fault, everything cleared.
      bus_q.push_back('{addr: 32'h304, be: 4'b0010, we: 1, wdata: 32'hA5A5A5A5,
                        rdata: 0, k: 50, cyc: 0});
      mem_write = 1'b1; funct3 = 3'd0; addr = 32'h305; store_data = 32'h000000A5; rd_in = 5'd12;
      @(posedge clk);
      #1 mem_write = 1'b0;
      @(negedge clk);
      chk("rst_mid_req_seen", bus_req, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_bus_req", bus_req, 0);
      chk("rst_mid_bus_addr", bus_addr, 0);
      chk("rst_mid_bus_be", bus_be, 0);
      chk("rst_mid_bus_wdata", bus_wdata, 0);
      chk("rst_mid_bus_we", bus_we, 0);
      chk("rst_mid_rd_out", rd_out, 0);
      chk("rst_mid_stall", stall, 0);
      chk("rst_mid_pulses", {30'h0, done, fault}, 0);
      bus_q.delete();
      @(posedge clk);
      #1;
      do_txn(1, 0, 3'd2, 32'h400, 32'h0, 32'hCAFEF00D, 5'd13, 1);

      for (int i = 0; i < 150; i++) rand_txn();

      repeat (4) @(posedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("bus_q_drained", bus_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
